// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: per-instruction prediction metadata
// carried from IF to EX, and the mispredict cause classification.
package bru_pkg;

  localparam int WIDTH   = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic             pred_jump;
    logic [WIDTH-1:0] pred_addr;
  } pred_meta_t;

  typedef enum logic [1:0] {
    NONE,
    DIR,
    TARGET,
    ALIAS
  } mispredict_cause_t;

endpackage

// File: rtl/bru_stage_reg.sv
// One pipeline stage of prediction metadata. kill clears only the valid bit
// and takes precedence over load; load=0 holds the stage.
module bru_stage_reg
  import bru_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       kill,
  input  pred_meta_t d,
  output pred_meta_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (kill) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: compares carried predictions against the real outcome,
// drives predictor updates and the fetch redirect. Optional counters via BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int WIDTH   = bru_pkg::WIDTH,
  parameter int PC_STEP = bru_pkg::PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             if_pred_jump,
  input  logic [WIDTH-1:0] if_pred_addr,
  input  logic             stall,
  input  logic             ext_flush,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  output logic [WIDTH-1:0] upd_pc,
  output logic             upd_branch,
  output logic             upd_taken,
  output logic [WIDTH-1:0] upd_addr,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
);

  pred_meta_t        if_meta;
  pred_meta_t        id_q;
  pred_meta_t        ex_q;
  logic              commit;
  logic              mispredict;
  logic              kill_stages;
  logic [WIDTH-1:0]  seq_pc;
  mispredict_cause_t cause;

  assign if_meta = '{valid: if_valid, pc: if_pc, pred_jump: if_pred_jump, pred_addr: if_pred_addr};

  // Both flush sources squash ID and EX; mispredict already implies !stall via commit
  assign kill_stages = ext_flush | mispredict;

  bru_stage_reg u_id (
    .clk  (clk),
    .rst  (rst),
    .load (~stall),
    .kill (kill_stages),
    .d    (if_meta),
    .q    (id_q)
  );

  bru_stage_reg u_ex (
    .clk  (clk),
    .rst  (rst),
    .load (~stall),
    .kill (kill_stages),
    .d    (id_q),
    .q    (ex_q)
  );

  assign commit = ex_q.valid & ~stall & ~ext_flush;

  always_comb begin
    cause = NONE;
    if (commit) begin
      if (ex_is_branch) begin
        if (ex_taken != ex_q.pred_jump) begin
          cause = DIR;
        end else if (ex_taken && (ex_target != ex_q.pred_addr)) begin
          cause = TARGET;
        end
      end else if (ex_q.pred_jump) begin
        cause = ALIAS;
      end
    end
  end

  assign mispredict = (cause != NONE);

  assign upd_pc     = ex_q.pc;
  assign upd_branch = commit & ex_is_branch;
  assign upd_taken  = ex_taken;
  assign upd_addr   = ex_target;

  // Sequential successor wraps at the top of the address space
  assign seq_pc      = ex_q.pc + WIDTH'(PC_STEP);
  assign redirect    = mispredict;
  assign redirect_pc = !mispredict ? '0 :
                       (ex_taken & ex_is_branch) ? ex_target : seq_pc;

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (upd_branch && (branch_cnt != 32'hFFFF_FFFF)) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (redirect && (mispredict_cnt != 32'hFFFF_FFFF)) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
    end
  end

  assign stat_branches    = branch_cnt;
  assign stat_mispredicts = mispredict_cnt;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then random traffic,
// checked against a queue-based model of instructions in flight.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_jump;
  logic [31:0] if_pred_addr;
  logic        stall;
  logic        ext_flush;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] upd_pc;
  logic        upd_branch;
  logic        upd_taken;
  logic [31:0] upd_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk              (clk),
    .rst              (rst),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_pred_jump     (if_pred_jump),
    .if_pred_addr     (if_pred_addr),
    .stall            (stall),
    .ext_flush        (ext_flush),
    .ex_is_branch     (ex_is_branch),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .upd_pc           (upd_pc),
    .upd_branch       (upd_branch),
    .upd_taken        (upd_taken),
    .upd_addr         (upd_addr),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  // An instruction's age counts unstalled edges since fetch; age 2 means it sits in EX
  typedef struct {
    logic [31:0] pc;
    logic        pj;
    logic [31:0] pa;
    int          age;
  } instr_t;

  instr_t      pipe[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] modelBranches = 32'd0;
  logic [31:0] modelMispredicts = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exIndex();
    foreach (pipe[i]) if (pipe[i].age == 2) return i;
    return -1;
  endfunction

  function automatic logic [31:0] expStat(input logic [31:0] cnt);
`ifdef BRU_STATS_EN
    return cnt;
`else
    return (cnt & 32'd0);
`endif
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, then advance the model
  task automatic applyStimulus(input logic ifv, input logic [31:0] pc, input logic pj,
                               input logic [31:0] pa, input logic st, input logic fl,
                               input logic br, input logic tk, input logic [31:0] tg);
    int          k;
    logic        exValid;
    logic        com;
    logic        mis;
    logic [31:0] expRpc;
    instr_t      e;
    instr_t      nq[$];
    @(negedge clk);
    if_valid     = ifv;
    if_pc        = pc;
    if_pred_jump = pj;
    if_pred_addr = pa;
    stall        = st;
    ext_flush    = fl;
    ex_is_branch = br;
    ex_taken     = tk;
    ex_target    = tg;
    #1;
    k       = exIndex();
    exValid = (k >= 0);
    e       = exValid ? pipe[k] : '{pc: 32'd0, pj: 1'b0, pa: 32'd0, age: 0};
    com     = exValid && !st && !fl;
    mis     = com && (br ? ((tk != e.pj) || (tk && (tg != e.pa))) : e.pj);
    expRpc  = !mis ? 32'd0 : (br && tk) ? tg : e.pc + 32'd4;
    checkOutput("upd_branch", 32'(upd_branch), 32'(com && br));
    checkOutput("upd_taken", 32'(upd_taken), 32'(tk));
    checkOutput("upd_addr", upd_addr, tg);
    checkOutput("redirect", 32'(redirect), 32'(mis));
    checkOutput("redirect_pc", redirect_pc, expRpc);
    if (exValid) checkOutput("upd_pc", upd_pc, e.pc);
    checkOutput("stat_branches", stat_branches, expStat(modelBranches));
    checkOutput("stat_mispredicts", stat_mispredicts, expStat(modelMispredicts));
    if (com && br && modelBranches != 32'hFFFF_FFFF) modelBranches++;
    if (mis && modelMispredicts != 32'hFFFF_FFFF) modelMispredicts++;
    if (fl || mis) begin
      pipe.delete();
    end else if (!st) begin
      foreach (pipe[i]) if (pipe[i].age < 2) nq.push_back('{pc: pipe[i].pc, pj: pipe[i].pj, pa: pipe[i].pa, age: pipe[i].age + 1});
      if (ifv) nq.push_back('{pc: pc, pj: pj, pa: pa, age: 1});
      pipe = nq;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Reset raised between edges must clear outputs without waiting for a clock
  task automatic resetMidCycle(input string tag);
    @(negedge clk);
    {if_valid, if_pred_jump, stall, ext_flush, ex_is_branch, ex_taken} = '0;
    if_pc = 32'd0; if_pred_addr = 32'd0; ex_target = 32'd0;
    #1 rst = 1'b1;
    #1;
    checkOutput({tag, "_upd_pc"}, upd_pc, 32'd0);
    checkOutput({tag, "_upd_branch"}, 32'(upd_branch), 32'd0);
    checkOutput({tag, "_redirect"}, 32'(redirect), 32'd0);
    checkOutput({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    checkOutput({tag, "_stat_br"}, stat_branches, 32'd0);
    checkOutput({tag, "_stat_mis"}, stat_mispredicts, 32'd0);
    pipe.delete();
    modelBranches = 32'd0;
    modelMispredicts = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst = 1'b1;
    {if_valid, if_pred_jump, stall, ext_flush, ex_is_branch, ex_taken} = '0;
    if_pc = 32'd0; if_pred_addr = 32'd0; ex_target = 32'd0;
    #2;
    checkOutput("rst_upd_branch", 32'(upd_branch), 32'd0);
    checkOutput("rst_redirect", 32'(redirect), 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("rst_upd_pc", upd_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Five resolved branches, the fourth and fifth mispredicting
    for (int c = 0; c < 9; c++)
      applyStimulus(1'b1, 32'h1000 + 32'(4 * c), 1'b0, 32'd0, 1'b0, 1'b0, 1'b1,
                    1'((c == 5) || (c == 8)), 32'h3000);
    applyStimulus(1'b1, 32'h1024, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("stats_branches_5", stat_branches, expStat(32'd5));
    checkOutput("stats_mispredicts_2", stat_mispredicts, expStat(32'd2));
    idle();
    resetMidCycle("midrst");

    // Correctly predicted not-taken branch
    applyStimulus(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104);
    checkOutput("nt_upd_branch", 32'(upd_branch), 32'd1);
    checkOutput("nt_upd_pc", upd_pc, 32'h100);
    checkOutput("nt_redirect", 32'(redirect), 32'd0);

    // Direction mispredict squashes the younger instruction
    applyStimulus(1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h204, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h208, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h340);
    checkOutput("dir_redirect", 32'(redirect), 32'd1);
    checkOutput("dir_redirect_pc", redirect_pc, 32'h340);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("dir_squash", 32'(upd_branch), 32'd0);

    // Target mispredict, then a matching target
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h480);
    checkOutput("tgt_redirect", 32'(redirect), 32'd1);
    checkOutput("tgt_redirect_pc", redirect_pc, 32'h480);
    applyStimulus(1'b1, 32'h310, 1'b1, 32'h480, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h480);
    checkOutput("tgt_ok_redirect", 32'(redirect), 32'd0);

    // Alias hit on a non-branch at the top of memory wraps to zero
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("alias_redirect", 32'(redirect), 32'd1);
    checkOutput("alias_wrap_pc", redirect_pc, 32'd0);

    // Stall holds a mispredicting branch; one redirect pulse on release
    applyStimulus(1'b1, 32'h500, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle();
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 32'h900, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h600);
      checkOutput("stall_redirect", 32'(redirect), 32'd0);
      checkOutput("stall_upd_branch", 32'(upd_branch), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h600);
    checkOutput("release_redirect", 32'(redirect), 32'd1);
    checkOutput("release_pc", redirect_pc, 32'h600);
    idle();
    checkOutput("release_once", 32'(redirect), 32'd0);

    // External flush beats a would-be mispredict and empties ID and EX
    applyStimulus(1'b1, 32'h700, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h704, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h708, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h800);
    checkOutput("flush_redirect", 32'(redirect), 32'd0);
    checkOutput("flush_upd_branch", 32'(upd_branch), 32'd0);
    for (int s = 0; s < 2; s++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h800);
      checkOutput("flush_empty", 32'(upd_branch), 32'd0);
    end

    // Random traffic with a small address pool so predicted targets collide often
    for (int r = 0; r < 400; r++) begin
      applyStimulus(1'($urandom % 4 != 0),
                    ($urandom % 8 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                    1'($urandom % 2),
                    32'h8000 + 32'(4 * ($urandom % 4)),
                    1'($urandom % 5 == 0),
                    1'($urandom % 16 == 0),
                    1'($urandom % 3 != 0),
                    1'($urandom % 2),
                    32'h8000 + 32'(4 * ($urandom % 4)));
    end
    resetMidCycle("endrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-side counterpart of the fetch-stage branch predictor.
- Carries each fetched instruction's prediction (predicted-taken bit and predicted target) through ID to EX and compares it with the real branch outcome.
- Drives the predictor update interface (EXPC, EXBranch, EXBranchTaken, EXBranchAddr) and produces the mispredict redirect/flush for the fetch unit.

Parameters:
- WIDTH, 32, PC and address width.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  IF holds a real instruction this cycle
- if_pc  in  WIDTH  PC of IF instruction
- if_pred_jump  in  1  predictor's predictJump for if_pc
- if_pred_addr  in  WIDTH  predictor's jumpAddr for if_pc
- stall  in  1  pipeline freeze; stage registers hold
- ext_flush  in  1  exception/trap flush; squashes ID and EX
- ex_is_branch  in  1  EX instruction is a branch/jump (datapath, combinational)
- ex_taken  in  1  actual direction resolved in EX
- ex_target  in  WIDTH  actual target resolved in EX
- upd_pc  out  WIDTH  EXPC to predictor
- upd_branch  out  1  EXBranch to predictor
- upd_taken  out  1  EXBranchTaken to predictor
- upd_addr  out  WIDTH  EXBranchAddr to predictor
- redirect  out  1  mispredict; fetch must load redirect_pc
- redirect_pc  out  WIDTH  correct next PC
- stat_branches  out  32  resolved-branch count (optional feature)
- stat_mispredicts  out  32  mispredict count (optional feature)

Behaviour:
- Stage registers: ID and EX, each holding {valid, pc, pred_jump, pred_addr}. Reset (async, rst high) clears all fields to 0.
- Per posedge, priority order:
  - rst: clear.
  - ext_flush: ID.valid and EX.valid cleared, other fields don't-care. Wins over stall and mispredict.
  - stall: both stages hold.
  - mispredict: ID.valid and EX.valid cleared.
  - otherwise: EX<=ID, ID<={if_valid, if_pc, if_pred_jump, if_pred_addr}.
- commit = EX.valid & !stall & !ext_flush.
- Update interface is combinational from the EX stage and datapath inputs:
  - upd_branch = commit & ex_is_branch
  - upd_taken = ex_taken
  - upd_addr = ex_target
  - upd_pc = EX.pc
  - upd_branch is never high while stall=1, so a held instruction updates exactly once.
- Mispredict = commit & any of:
  - ex_is_branch & (ex_taken != EX.pred_jump)
  - ex_is_branch & ex_taken & EX.pred_jump & (ex_target != EX.pred_addr)
  - !ex_is_branch & EX.pred_jump (alias hit on a non-branch)
- Redirect outputs:
  - redirect = mispredict, asserted in the same cycle as EX commit.
  - redirect_pc = ex_taken & ex_is_branch ? ex_target : EX.pc + PC_STEP.
  - The add is WIDTH bits and wraps modulo 2^WIDTH (0xFFFFFFFC -> 0x00000000).
- Latency:
  - Instruction in IF at cycle t is in EX at t+2 absent stalls.
  - Redirect is combinational at that cycle. The instruction entering ID on the same edge is squashed, so it is never seen in EX.
- Simultaneous events:
  - Mispredict together with if_valid: the IF instruction is dropped; fetch re-issues from redirect_pc next cycle.
  - ext_flush in the same cycle as a would-be mispredict: commit=0, so redirect=0 and upd_branch=0.
- Reset values: all outputs 0 (redirect_pc = 0 + PC_STEP is don't-care while redirect=0; driven 0 by gating with redirect).
- Reset asserted mid-operation clears state immediately. Outputs go 0 asynchronously.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined:
  - Two 32-bit counters, async-reset to 0.
  - stat_branches increments on upd_branch; stat_mispredicts increments on redirect.
  - Both saturate at 0xFFFFFFFF (no wrap).
- Undefined: ports still present, tied to 0, no counter flops.

Decomposition:
- Package bru_pkg holds:
  - typedef pred_meta_t (valid, pc, pred_jump, pred_addr) parameterised via WIDTH localparam.
  - localparam PC_STEP default.
  - Enum mispredict_cause_t {NONE, DIR, TARGET, ALIAS}, used internally and for waveform debug.
- One sub-module, bru_stage_reg: one pred_meta_t register with stall/flush/async reset. Instantiated twice (ID, EX).

Test Plan:
- Predict not-taken, actual not-taken: if_pc=0x100, if_pred_jump=0, ex_is_branch=1, ex_taken=0 at t+2 -> upd_branch=1, upd_taken=0, upd_pc=0x100, redirect=0.
- Direction mispredict: if_pc=0x200, pred_jump=0; EX ex_taken=1, ex_target=0x340 -> redirect=1, redirect_pc=0x340. The following instruction (0x204) never reaches EX (upd_branch=0 next cycle).
- Target mispredict: pred_jump=1, pred_addr=0x400, ex_target=0x480 -> redirect=1, redirect_pc=0x480. With pred_addr=0x480 -> redirect=0.
- Alias plus wrap: if_pc=0xFFFFFFFC, pred_jump=1, ex_is_branch=0 -> redirect=1, redirect_pc=0x00000000.
- Stall/flush: hold stall=1 for 3 cycles with a mispredicting branch in EX -> redirect=0 and upd_branch=0 throughout; single redirect pulse on release. ext_flush with the same branch -> no redirect, ID/EX valid=0 next cycle.
- Reset mid-stream, with BRU_STATS_EN: after 5 branches with 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Assert rst between edges -> all outputs 0 immediately and counters 0.
